// File: rtl/dec_gray2bin_sync.sv
// Gray-code consumer: resynchronises gray_in, decodes to registered binary, and reports change/delta/multi-bit errors.
// Optional saturating error counter output err_cnt when GRAY_DEC_ERR_CNT_EN is defined.
module dec_gray2bin_sync #(
   parameter int WIDTH       = 12,
   parameter int SYNC_STAGES = 2   // legal range 2..4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] gray_in,
   input  logic             en,
   input  logic             err_clr,
   output logic [WIDTH-1:0] bin_out,
   output logic             chg,
   output logic [WIDTH-1:0] delta,
   output logic             err_multi,
`ifdef GRAY_DEC_ERR_CNT_EN
   output logic [7:0]       err_cnt,
`endif
   output logic             ready
);

   typedef enum logic [1:0] {FLUSH, PRIME, TRACK} state_t;

   localparam logic [2:0]       FLUSH_LAST = 3'(SYNC_STAGES - 1);
   localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);

   state_t           state;
   state_t           next_state;
   logic [2:0]       flush_cnt;
   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] prev_gray;
   logic [WIDTH-1:0] g_s;
   logic [WIDTH-1:0] g_diff;
   logic [WIDTH-1:0] g_dec;
   logic             update;
   logic             detect;

   function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
      logic [WIDTH-1:0] b;
      b[WIDTH-1] = g[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

   // Synchroniser chain runs in every state, independent of en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= gray_in;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign g_s    = sync_q[SYNC_STAGES-1];
   assign g_diff = g_s ^ prev_gray;
   assign g_dec  = gray2bin(g_s);
   assign update = (state == TRACK) && en && (g_s != prev_gray);
   // Clearing the lowest set bit leaves something only if two or more bits differ
   assign detect = update && (|(g_diff & (g_diff - ONE)));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= FLUSH;
         flush_cnt <= '0;
      end else begin
         state     <= next_state;
         flush_cnt <= (state == FLUSH && flush_cnt != FLUSH_LAST) ? flush_cnt + 3'd1 : 3'd0;
      end
   end

   always_comb begin
      next_state = state;
      case (state)
         FLUSH:   if (flush_cnt == FLUSH_LAST) next_state = PRIME;
         PRIME:   next_state = TRACK;
         TRACK:   next_state = TRACK;
         default: next_state = FLUSH;
      endcase
   end

   // PRIME seeds the reference without reporting; TRACK reports each distinct sample
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev_gray <= '0;
         bin_out   <= '0;
         delta     <= '0;
         chg       <= 1'b0;
         err_multi <= 1'b0;
         ready     <= 1'b0;
      end else begin
         ready <= (next_state == TRACK);
         if (state == PRIME) begin
            prev_gray <= g_s;
            bin_out   <= g_dec;
         end else if (state == TRACK) begin
            chg <= update;
            if (update) begin
               prev_gray <= g_s;
               bin_out   <= g_dec;
               delta     <= g_dec - bin_out;
            end
         end
         if (detect)       err_multi <= 1'b1;
         else if (err_clr) err_multi <= 1'b0;
      end
   end

`ifdef GRAY_DEC_ERR_CNT_EN
   // A clear coinciding with a new error restarts the count at one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_cnt <= '0;
      end else if (detect) begin
         if (err_clr)               err_cnt <= 8'd1;
         else if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
      end else if (err_clr) begin
         err_cnt <= '0;
      end
   end
`endif

endmodule

// File: tb/tb_dec_gray2bin_sync.sv
// Directed self-checking bench for dec_gray2bin_sync (default WIDTH=12, SYNC_STAGES=2).
// Also checks err_cnt when GRAY_DEC_ERR_CNT_EN is defined.
module tb_dec_gray2bin_sync;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] gray_in;
   logic        en;
   logic        err_clr;
   logic [11:0] bin_out;
   logic        chg;
   logic [11:0] delta;
   logic        err_multi;
   logic        ready;
`ifdef GRAY_DEC_ERR_CNT_EN
   logic [7:0]  err_cnt;
`endif

   int checks = 0;
   int errors = 0;

   dec_gray2bin_sync dut (
      .clk       (clk),
      .rst       (rst),
      .gray_in   (gray_in),
      .en        (en),
      .err_clr   (err_clr),
      .bin_out   (bin_out),
      .chg       (chg),
      .delta     (delta),
      .err_multi (err_multi),
`ifdef GRAY_DEC_ERR_CNT_EN
      .err_cnt   (err_cnt),
`endif
      .ready     (ready)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [11:0] g, input logic e, input logic clr);
      gray_in = g;
      en      = e;
      err_clr = clr;
   endtask

   task automatic waitEdges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      // Startup from gray 0
      rst = 1'b1;
      applyStimulus(12'h000, 1'b1, 1'b0);
      waitEdges(2);
      checkOutput("rst_bin", 32'(bin_out), 32'h000);
      checkOutput("rst_ready", 32'(ready), 32'h0);
      checkOutput("rst_chg", 32'(chg), 32'h0);
      checkOutput("rst_delta", 32'(delta), 32'h000);
      checkOutput("rst_err", 32'(err_multi), 32'h0);
      rst = 1'b0;
      waitEdges(1);
      checkOutput("start_e1_ready", 32'(ready), 32'h0);
      waitEdges(1);
      checkOutput("start_e2_ready", 32'(ready), 32'h0);
      waitEdges(1);
      checkOutput("start_e3_ready", 32'(ready), 32'h1);
      checkOutput("start_e3_bin", 32'(bin_out), 32'h000);
      applyStimulus(12'h001, 1'b1, 1'b0);
      waitEdges(2);
      checkOutput("step_early_bin", 32'(bin_out), 32'h000);
      checkOutput("step_early_chg", 32'(chg), 32'h0);
      waitEdges(1);
      checkOutput("step_bin", 32'(bin_out), 32'h001);
      checkOutput("step_chg", 32'(chg), 32'h1);
      checkOutput("step_delta", 32'(delta), 32'h001);
      checkOutput("step_err", 32'(err_multi), 32'h0);
      waitEdges(1);
      checkOutput("step_chg_drop", 32'(chg), 32'h0);

      // Prime at 0xFFF, then wrap to 0 and count up to 9
      rst = 1'b1;
      applyStimulus(12'h800, 1'b1, 1'b0);
      waitEdges(1);
      rst = 1'b0;
      waitEdges(3);
      checkOutput("prime_ready", 32'(ready), 32'h1);
      checkOutput("prime_bin", 32'(bin_out), 32'hFFF);
      for (int n = 0; n < 10; n++) begin
         applyStimulus(12'(n ^ (n >> 1)), 1'b1, 1'b0);
         waitEdges(2);
         checkOutput($sformatf("cnt%0d_pre_chg", n), 32'(chg), 32'h0);
         waitEdges(1);
         checkOutput($sformatf("cnt%0d_bin", n), 32'(bin_out), 32'(n));
         checkOutput($sformatf("cnt%0d_chg", n), 32'(chg), 32'h1);
         checkOutput($sformatf("cnt%0d_delta", n), 32'(delta), 32'h001);
         waitEdges(1);
         checkOutput($sformatf("cnt%0d_post_chg", n), 32'(chg), 32'h0);
      end
      checkOutput("cnt_err", 32'(err_multi), 32'h0);

      // Asynchronous reset mid-run at bin_out=9
      #2;
      rst = 1'b1;
      applyStimulus(12'h000, 1'b1, 1'b0);
      #1;
      checkOutput("midrst_bin", 32'(bin_out), 32'h000);
      checkOutput("midrst_ready", 32'(ready), 32'h0);
      checkOutput("midrst_delta", 32'(delta), 32'h000);
      checkOutput("midrst_err", 32'(err_multi), 32'h0);
      waitEdges(1);
      rst = 1'b0;
      waitEdges(2);
      checkOutput("restart_e2_ready", 32'(ready), 32'h0);
      waitEdges(1);
      checkOutput("restart_e3_ready", 32'(ready), 32'h1);
      checkOutput("restart_bin", 32'(bin_out), 32'h000);

      // Multi-bit jump 0x000 -> 0x003
      applyStimulus(12'h003, 1'b1, 1'b0);
      waitEdges(3);
      checkOutput("jump_bin", 32'(bin_out), 32'h002);
      checkOutput("jump_delta", 32'(delta), 32'h002);
      checkOutput("jump_chg", 32'(chg), 32'h1);
      checkOutput("jump_err", 32'(err_multi), 32'h1);
`ifdef GRAY_DEC_ERR_CNT_EN
      checkOutput("jump_errcnt", 32'(err_cnt), 32'h01);
`endif
      // Jump back with err_clr on the detect edge: set wins
      applyStimulus(12'h000, 1'b1, 1'b0);
      waitEdges(2);
      applyStimulus(12'h000, 1'b1, 1'b1);
      waitEdges(1);
      checkOutput("jump2_err", 32'(err_multi), 32'h1);
      checkOutput("jump2_bin", 32'(bin_out), 32'h000);
      checkOutput("jump2_delta", 32'(delta), 32'hFFE);
      checkOutput("jump2_chg", 32'(chg), 32'h1);
`ifdef GRAY_DEC_ERR_CNT_EN
      checkOutput("jump2_errcnt", 32'(err_cnt), 32'h01);
`endif
      waitEdges(1);
      checkOutput("clr_err", 32'(err_multi), 32'h0);
`ifdef GRAY_DEC_ERR_CNT_EN
      checkOutput("clr_errcnt", 32'(err_cnt), 32'h00);
`endif
      applyStimulus(12'h000, 1'b1, 1'b0);

      // Enable hold: settle at Gray(1), walk Gray(2..5) with en low
      applyStimulus(12'h001, 1'b1, 1'b0);
      waitEdges(4);
      checkOutput("hold_base_bin", 32'(bin_out), 32'h001);
      checkOutput("hold_base_err", 32'(err_multi), 32'h0);
      for (int n = 2; n <= 5; n++) begin
         applyStimulus(12'(n ^ (n >> 1)), 1'b0, 1'b0);
         waitEdges(4);
         checkOutput($sformatf("hold%0d_bin", n), 32'(bin_out), 32'h001);
         checkOutput($sformatf("hold%0d_chg", n), 32'(chg), 32'h0);
      end
      applyStimulus(12'h007, 1'b1, 1'b0);
      waitEdges(1);
      checkOutput("resume_bin", 32'(bin_out), 32'h005);
      checkOutput("resume_delta", 32'(delta), 32'h004);
      checkOutput("resume_chg", 32'(chg), 32'h1);
      checkOutput("resume_err", 32'(err_multi), 32'h1);
`ifdef GRAY_DEC_ERR_CNT_EN
      checkOutput("resume_errcnt", 32'(err_cnt), 32'h01);
`endif
      waitEdges(1);
      checkOutput("resume_chg_drop", 32'(chg), 32'h0);
      checkOutput("resume_bin_hold", 32'(bin_out), 32'h005);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/dec_gray2bin_sync.md
Name: dec_gray2bin_sync

Overview:
- Consumer stage for the enc_bin2gray output: receives a Gray-coded pointer/count, typically from another clock domain.
- Resynchronises it through a flop chain, then decodes it back to binary in registered form.
- Reports per-update change strobe, modular delta, and a sticky error when more than one Gray bit changes between samples.
- Sits directly downstream of enc_bin2gray in FIFO pointer and position-counter paths.

Parameters:
- WIDTH, 12, bit width of the Gray input and the binary output.
- SYNC_STAGES, 2, number of synchroniser flops on gray_in; legal range 2..4.

Ports:
- clk  input  1  single clock for all logic.
- rst  input  1  asynchronous, active-high reset.
- gray_in  input  WIDTH  Gray-coded value; may be asynchronous to clk.
- en  input  1  decode/compare enable; synchroniser always runs.
- err_clr  input  1  clears err_multi.
- bin_out  output  WIDTH  decoded binary value.
- chg  output  1  one-cycle pulse when bin_out updated to a different value.
- delta  output  WIDTH  (new bin_out - previous bin_out) mod 2^WIDTH; valid when chg=1.
- err_multi  output  1  sticky: more than one Gray bit changed between compared samples.
- ready  output  1  high once the startup sequence completes.

Behaviour:
- Async reset values: all sync flops 0, prev_gray 0, bin_out 0, delta 0, chg 0, err_multi 0, ready 0, FSM in FLUSH with counter 0.
- Synchroniser: gray_in passes through SYNC_STAGES flops; the last stage is g_s. The chain runs regardless of en or FSM state.
- FSM state FLUSH: counts SYNC_STAGES edges, then moves to PRIME. No output changes in FLUSH.
- FSM state PRIME: lasts one edge. Loads prev_gray=g_s and bin_out=decode(g_s). chg, delta and err are not touched. Moves to TRACK.
- FSM state TRACK: ready=1, registered from state.
  - bin_out first reflects gray_in at rising edge SYNC_STAGES+1 after reset release.
- TRACK with en=1 and g_s!=prev_gray, all on one edge:
  - bin_out <= decode(g_s).
  - delta <= decode(g_s) - bin_out, truncated to WIDTH.
  - chg <= 1.
  - prev_gray <= g_s.
  - If popcount(g_s ^ prev_gray) > 1, err_multi <= 1.
- TRACK with en=1 and g_s==prev_gray: chg <= 0; all other outputs hold.
- en=0: bin_out, delta, prev_gray and err_multi hold; chg <= 0. On the first en=1 cycle, the comparison uses the held prev_gray. The accumulated delta and a multi-bit change are reported once.
- decode: b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1]^g[i]. Purely combinational inside the register stage.
- Latency: gray_in change to bin_out/chg is SYNC_STAGES+1 edges, i.e. 3 at default.
- Wrap-around: delta is modular. Binary 0xFFF->0x000 gives delta=0x001 with no error.
- err_multi set vs err_clr on the same edge: set wins. err_clr alone clears on the next edge.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). The FSM restarts the FLUSH/PRIME sequence after release.

Optional Feature:
- Macro: GRAY_DEC_ERR_CNT_EN.
- Defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments on every edge where a multi-bit change is detected in TRACK.
  - Saturates at 0xFF; cleared by err_clr.
  - Increment on the same edge as err_clr: result is 1.
- Undefined: err_cnt port and counter are absent; all other behaviour is identical.

Test Plan:
- Startup (WIDTH=12): rst high, gray_in=0x000, release rst -> ready=1 from edge 3. Step gray_in to 0x001 -> 3 edges later bin_out=0x001, chg=1 for one cycle, delta=0x001, err_multi=0.
- Count sequence: gray_in = Gray(0..9), one value per 4 cycles -> bin_out steps 0..9, ten chg pulses, each with delta=1, err_multi stays 0.
- Wrap: prime at gray_in=0x800 (bin 0xFFF), then gray_in=0x000 -> bin_out=0x000, delta=0x001, err_multi=0.
- Multi-bit jump: gray_in 0x000->0x003 -> bin_out=0x002, delta=0x002, err_multi=1 (err_cnt=1 when macro defined). Then repeat the jump with err_clr high on the detect edge -> err_multi stays 1. Then err_clr alone -> err_multi=0.
- Enable hold: en=0, gray_in walks Gray(1..5) -> bin_out holds, chg=0. Set en=1 -> single chg pulse, bin_out=5, delta=4, err_multi=1 (0x001 vs 0x007 differ in 2 bits).
- Reset mid-run: at bin_out=0x009, assert rst between edges -> bin_out=0, ready=0, err_multi=0 immediately. After release, ready=1 again at edge 3.
